// File: rtl/audio_out_buffer.sv
// audio_out_buffer: elastic sample FIFO feeding a gain-ramped, click-free stereo output
// stage that follows the Audio_Controller audio_out_allowed / write_audio_out handshake.
module audio_out_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    input  logic                     play,
    input  logic                     audio_out_allowed,
    output logic                     write_audio_out,
    output logic [31:0]              left_channel_audio_out,
    output logic [31:0]              right_channel_audio_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned GAIN_MAX = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SCALE = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [8:0]         gain_q, gain_d;
    logic [15:0]        sample_q, sample_d;
    logic signed [24:0] prod_q, prod_d;
    logic [15:0]        scaled_q, scaled_d;
    logic [15:0]        out_q, out_d;
    logic               wr_q, wr_d;

    logic               empty_c;
    logic               full_c;
    logic               pop_c;
    logic               push_c;
    logic signed [24:0] sample_ext_c;
    logic signed [24:0] gain_ext_c;
    logic [9:0]         gain_up_c;

    assign empty_c = (level_q == LW'(0));
    assign full_c  = (level_q == LW'(DEPTH));
    assign pop_c   = (state_q == IDLE) && audio_out_allowed && !empty_c && !clear;
    assign push_c  = sample_valid && (!full_c || pop_c) && !clear;

    assign sample_ext_c = {{9{sample_q[15]}}, sample_q};
    assign gain_ext_c   = {16'b0, gain_q};
    assign gain_up_c    = {1'b0, gain_q} + 10'(RAMP_STEP);

    assign write_audio_out         = wr_q;
    assign left_channel_audio_out  = {out_q, 16'b0};
    assign right_channel_audio_out = {out_q, 16'b0};
    assign fifo_level              = level_q;
    assign overflow                = ovf_q;

    // FIFO storage; no reset needed since occupancy is tracked by level_q
    always_ff @(posedge CLOCK_50) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // Next-state: FIFO bookkeeping, pipeline FSM, gain ramp and output strobe
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        gain_d   = gain_q;
        sample_d = sample_q;
        prod_d   = prod_q;
        scaled_d = scaled_q;
        out_d    = out_q;
        wr_d     = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            gain_d   = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else if (sample_valid) begin
                ovf_d = 1'b1;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                sample_d = mem_q[rd_ptr_q];
            end
            level_d = level_q + LW'(push_c) - LW'(pop_c);

            case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    prod_d  = sample_ext_c * gain_ext_c;
                    state_d = SCALE;
                end
                SCALE: begin
                    // |gain| <= 256 so the shifted product always fits in 16 bits
                    scaled_d = prod_q[23:8];
                    state_d  = WRITE;
                end
                WRITE: begin
                    if (audio_out_allowed) begin
                        out_d   = scaled_q;
                        wr_d    = 1'b1;
                        state_d = IDLE;
                        if (play) begin
                            gain_d = (gain_up_c > 10'(GAIN_MAX)) ? 9'(GAIN_MAX) : gain_up_c[8:0];
                        end else begin
                            gain_d = (gain_q < 9'(RAMP_STEP)) ? 9'd0 : gain_q - 9'(RAMP_STEP);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            gain_q   <= '0;
            sample_q <= '0;
            prod_q   <= '0;
            scaled_q <= '0;
            out_q    <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            gain_q   <= gain_d;
            sample_q <= sample_d;
            prod_q   <= prod_d;
            scaled_q <= scaled_d;
            out_q    <= out_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_audio_out_buffer.sv
// Self-checking bench for audio_out_buffer: expected writes queued at push time,
// compared in order whenever the DUT strobes write_audio_out.
module tb_audio_out_buffer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        play;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [3:0]  fifo_level;
    logic        overflow;

    audio_out_buffer #(.DEPTH(8), .RAMP_STEP(4)) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .clear                   (clear),
        .sample_in               (sample_in),
        .sample_valid            (sample_valid),
        .play                    (play),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .fifo_level              (fifo_level),
        .overflow                (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [15:0] s;
        logic [31:0] e;
    } vec_t;

    logic [31:0] sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mdl_gain = 0;
    logic [31:0] last_left = 32'h0;
    logic [31:0] mon_exp;
    bit          prev_strobe = 1'b0;
    vec_t        vt1 [8];
    vec_t        vt3 [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int next_gain(input int g, input logic p);
        if (p) return (g + 4 > 256) ? 256 : g + 4;
        else   return (g - 4 < 0) ? 0 : g - 4;
    endfunction

    function automatic logic [31:0] exp_out(input logic [15:0] s, input int g);
        int p;
        p = $signed(s) * g;
        p = p >>> 8;
        return {p[15:0], 16'h0};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_x(input logic [15:0] s, input logic [31:0] exp, input bit rec);
        sample_in    = s;
        sample_valid = 1'b1;
        if (rec) begin
            sb.push_back(exp);
            mdl_gain = next_gain(mdl_gain, play);
        end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic push_m(input logic [15:0] s, input bit rec);
        push_x(s, exp_out(s, mdl_gain), rec);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || fifo_level != 4'd0) && k < 3000) begin
            tick();
            k++;
        end
        repeat (8) tick();
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation
    always @(negedge CLOCK_50) begin
        if (reset) begin
            prev_strobe = 1'b0;
        end else begin
            if (write_audio_out) begin
                check("strobe_allowed", 32'(audio_out_allowed), 32'd1);
                check("strobe_width", 32'(prev_strobe), 32'd0);
                check("left_eq_right", right_channel_audio_out, left_channel_audio_out);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got left=%h with no write expected", left_channel_audio_out);
                end else begin
                    mon_exp = sb.pop_front();
                    check("write_value", left_channel_audio_out, mon_exp);
                    last_left = mon_exp;
                end
            end
            prev_strobe = write_audio_out;
        end
    end

    initial begin
        vt1[0] = '{16'h1000, 32'h0000_0000};
        vt1[1] = '{16'h1000, 32'h0040_0000};
        vt1[2] = '{16'h1000, 32'h0080_0000};
        vt1[3] = '{16'h1000, 32'h00C0_0000};
        vt1[4] = '{16'h1000, 32'h0100_0000};
        vt1[5] = '{16'h1000, 32'h0140_0000};
        vt1[6] = '{16'h1000, 32'h0180_0000};
        vt1[7] = '{16'h1000, 32'h01C0_0000};
        vt3[0] = '{16'h8000, 32'h8000_0000};
        vt3[1] = '{16'h7FFF, 32'h7FFF_0000};

        reset = 1'b1;
        clear = 1'b0;
        sample_in = 16'h0;
        sample_valid = 1'b0;
        play = 1'b0;
        audio_out_allowed = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_strobe", 32'(write_audio_out), 32'd0);
        check("rst_left", left_channel_audio_out, 32'h0);
        check("rst_right", right_channel_audio_out, 32'h0);
        reset = 1'b0;
        tick();

        // Ramp-up table plus pop-to-strobe latency on the first sample
        play = 1'b1;
        audio_out_allowed = 1'b1;
        push_x(vt1[0].s, vt1[0].e, 1'b1);
        check("lat_level_push", 32'(fifo_level), 32'd1);
        tick();
        check("lat_level_pop", 32'(fifo_level), 32'd0);
        tick();
        check("lat_strobe_c1", 32'(write_audio_out), 32'd0);
        tick();
        check("lat_strobe_c2", 32'(write_audio_out), 32'd0);
        tick();
        check("lat_strobe_c3", 32'(write_audio_out), 32'd1);
        tick();
        check("lat_strobe_off", 32'(write_audio_out), 32'd0);
        for (int i = 1; i < 8; i++) push_x(vt1[i].s, vt1[i].e, 1'b1);
        drain();
        check("t1_ovf", 32'(overflow), 32'd0);

        // Fill past capacity with the output blocked: ninth push is dropped
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 9; i++) push_m(16'(32'h1357 * (i + 1)), (i < 8));
        check("t2_level_full", 32'(fifo_level), 32'd8);
        check("t2_ovf", 32'(overflow), 32'd1);
        audio_out_allowed = 1'b1;
        drain();
        check("t2_level_empty", 32'(fifo_level), 32'd0);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Ramp gain to full scale with random samples, then extremes at unity gain
        while (mdl_gain < 256) begin
            for (int i = 0; i < 8 && mdl_gain < 256; i++) push_m(16'($urandom), 1'b1);
            drain();
        end
        for (int i = 0; i < 2; i++) push_x(vt3[i].s, vt3[i].e, 1'b1);
        drain();

        // Fade-out: 64 writes bring gain to zero, later samples write zero
        play = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) push_m(16'h4000, 1'b1);
            drain();
        end
        for (int i = 0; i < 4; i++) push_x(16'h7FFF, 32'h0, 1'b1);
        drain();

        // Back-pressure while the result waits in WRITE
        play = 1'b1;
        for (int i = 0; i < 3; i++) push_m(16'h2000, 1'b1);
        drain();
        push_m(16'h2000, 1'b1);
        tick();
        tick();
        tick();
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_strobe", 32'(write_audio_out), 32'd0);
            check("t5_hold_left", left_channel_audio_out, last_left);
        end
        audio_out_allowed = 1'b1;
        tick();
        check("t5_release_strobe", 32'(write_audio_out), 32'd1);
        tick();
        check("t5_single_strobe", 32'(write_audio_out), 32'd0);
        drain();
        check("t5_left_value", left_channel_audio_out, 32'h0180_0000);

        // Synchronous clear mid-stream, then asynchronous reset mid-pipeline
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 5; i++) push_m(16'h0AAA, 1'b0);
        check("t6_level5", 32'(fifo_level), 32'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clr_level", 32'(fifo_level), 32'd0);
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        mdl_gain = 0;
        audio_out_allowed = 1'b1;
        push_x(16'h1234, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        check("t6_rst_strobe", 32'(write_audio_out), 32'd0);
        check("t6_rst_left", left_channel_audio_out, 32'h0);
        check("t6_rst_right", right_channel_audio_out, 32'h0);
        repeat (4) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("t6_post_level", 32'(fifo_level), 32'd0);
        check("t6_post_left", left_channel_audio_out, 32'h0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
